// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - IMEM runtime loader and CPU fetch gate (optional IMEM_LOAD_TIMEOUT_EN idle abort)
module imem_load_ctrl #(
  parameter int          DEPTH       = 256,
  parameter int          FETCH_LIMIT = 128,
  parameter logic [31:0] HALT_INSTR  = 32'h00000063,
  parameter int          TIMEOUT     = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [8:0]  load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic [7:0]  mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_stall,
  output logic        cpu_reset_req,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  load_count
);

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_DONE} state_t;

  localparam logic [8:0] LP_DEPTH = 9'(DEPTH);
  localparam logic [9:0] LP_LIMIT = 10'(FETCH_LIMIT);

  state_t      r_state;
  logic [8:0]  r_len;
  logic [8:0]  r_load_count;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic        r_mem_we;
  logic [7:0]  r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic        r_cpu_stall;
  logic        r_cpu_reset_req;
  logic        r_byte_ready;
  logic        r_load_busy;
  logic        r_load_done;
  logic        r_load_err;

  logic w_accept;
  logic w_last_word;
  logic w_in_window;
  logic w_timeout;
  logic w_unused_addr;

  assign w_accept      = r_byte_ready & byte_valid;
  assign w_last_word   = ((r_load_count + 9'd1) == r_len);
  assign w_in_window   = (fetch_addr[11:2] < LP_LIMIT);
  assign w_unused_addr = ^{fetch_addr[31:12], fetch_addr[1:0]};

`ifdef IMEM_LOAD_TIMEOUT_EN
  logic [31:0] r_idle;

  // Idle counter: counts LOAD cycles without an accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (r_state != S_LOAD || w_accept) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 32'd1;
    end
  end

  assign w_timeout = (r_state == S_LOAD) && !w_accept && (r_idle == 32'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  // Session FSM: byte assembly, sequential word writes, release pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_RUN;
      r_len           <= '0;
      r_load_count    <= '0;
      r_byte_cnt      <= '0;
      r_word          <= '0;
      r_mem_we        <= 1'b0;
      r_mem_waddr     <= '0;
      r_mem_wdata     <= '0;
      r_cpu_stall     <= 1'b0;
      r_cpu_reset_req <= 1'b0;
      r_byte_ready    <= 1'b0;
      r_load_busy     <= 1'b0;
      r_load_done     <= 1'b0;
      r_load_err      <= 1'b0;
    end else begin
      r_mem_we        <= 1'b0;
      r_load_done     <= 1'b0;
      r_cpu_reset_req <= 1'b0;
      r_load_err      <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (load_start && load_len != 9'd0) begin
            r_len        <= (load_len > LP_DEPTH) ? LP_DEPTH : load_len;
            r_load_count <= '0;
            r_byte_cnt   <= '0;
            r_state      <= S_LOAD;
            r_cpu_stall  <= 1'b1;
            r_byte_ready <= 1'b1;
            r_load_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= byte_data;
              2'd1: r_word[15:8]  <= byte_data;
              2'd2: r_word[23:16] <= byte_data;
              default: begin
                r_mem_we     <= 1'b1;
                r_mem_waddr  <= r_load_count[7:0];
                r_mem_wdata  <= {byte_data, r_word};
                r_load_count <= r_load_count + 9'd1;
                if (w_last_word) begin
                  r_state         <= S_DONE;
                  r_byte_ready    <= 1'b0;
                  r_load_busy     <= 1'b0;
                  r_load_done     <= 1'b1;
                  r_cpu_reset_req <= 1'b1;
                end
              end
            endcase
          end else if (w_timeout) begin
            r_state      <= S_RUN;
            r_cpu_stall  <= 1'b0;
            r_byte_ready <= 1'b0;
            r_load_busy  <= 1'b0;
            r_load_err   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_RUN;
          r_cpu_stall <= 1'b0;
        end
        default: begin
          r_state      <= S_RUN;
          r_cpu_stall  <= 1'b0;
          r_byte_ready <= 1'b0;
          r_load_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_raddr     = fetch_addr[9:2];
  assign fetch_instr   = (r_state == S_RUN && w_in_window) ? mem_rdata : HALT_INSTR;
  assign byte_ready    = r_byte_ready;
  assign mem_we        = r_mem_we;
  assign mem_waddr     = r_mem_waddr;
  assign mem_wdata     = r_mem_wdata;
  assign cpu_stall     = r_cpu_stall;
  assign cpu_reset_req = r_cpu_reset_req;
  assign load_busy     = r_load_busy;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign load_count    = r_load_count;

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Load controller and fetch gate for the 256-word instruction memory of the single-cycle RISC-V core. Runtime program download: stalls the CPU, assembles a little-endian byte stream into 32-bit words, and writes them sequentially from word 0. Releases the CPU with a one-cycle restart request. In RUN it forwards fetches and substitutes the halt instruction (`beq x0,x0,0`) for out-of-window addresses. Sits between the core's fetch port, the byte-stream source (UART/debug) and the IMEM array.

## Interface
- `DEPTH`, 256: IMEM words; write pointer and clamp limit.
- `FETCH_LIMIT`, 128: fetch window in words; word index >= this returns `HALT_INSTR`.
- `HALT_INSTR`, 32'h00000063: substituted instruction.
- `TIMEOUT`, 1_000_000: idle-cycle limit; only used with `IMEM_LOAD_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_start` in 1: request a load session; sampled in RUN only.
- `load_len` in 9: word count; captured with `load_start`.
- `byte_valid` in 1, `byte_data` in 8, `byte_ready` out 1: stream handshake; transfer when valid && ready.
- `fetch_addr` in 32: CPU PC (byte address).
- `fetch_instr` out 32: instruction to CPU.
- `mem_raddr` out 8: `fetch_addr[9:2]`, combinational.
- `mem_rdata` in 32: IMEM combinational read data.
- `mem_we` out 1, `mem_waddr` out 8, `mem_wdata` out 32: IMEM write port, registered.
- `cpu_stall` out 1: high in LOAD and DONE.
- `cpu_reset_req` out 1: one-cycle pulse in DONE; CPU restarts PC at 0.
- `load_busy` out 1: high in LOAD.
- `load_done` out 1: one-cycle pulse in DONE.
- `load_err` out 1: one-cycle abort pulse.
- `load_count` out 9: words written in current/last session.

## Operation
- States: RUN (reset state), LOAD, DONE.
- RUN: `byte_ready`=0. `fetch_instr` = `mem_rdata` if `fetch_addr[11:2]` < `FETCH_LIMIT`, else `HALT_INSTR`. `fetch_addr[1:0]` is ignored.
- RUN -> LOAD on `load_start`=1 with `load_len`!=0.
  - Capture len = min(`load_len`, `DEPTH`).
  - Clear write pointer, byte counter and `load_count`.
- `load_start` with `load_len`=0 is ignored. `load_start` in LOAD/DONE is ignored.
- LOAD: `byte_ready`=1; `fetch_instr`=`HALT_INSTR`.
  - Each accepted byte fills lane byte_cnt (byte 0 -> bits 7:0, little-endian).
  - On the 4th byte: next cycle `mem_we`=1, `mem_waddr`=wr_ptr, `mem_wdata`=assembled word; wr_ptr and `load_count` increment.
- The last word write moves LOAD -> DONE in the same cycle that `mem_we` is asserted.
- DONE, exactly one cycle: `load_done`=1, `cpu_reset_req`=1, `cpu_stall`=1, `byte_ready`=0, `fetch_instr`=`HALT_INSTR`. Then -> RUN.
- Bytes offered after the final byte are not accepted (ready low). Write pointer never wraps (clamped length).
- `rst` asserted mid-load: immediate return to RUN, partial word discarded, no further writes. Words already written remain in IMEM.

## Timing
- Reset values: `cpu_stall`, `cpu_reset_req`, `mem_we`, `byte_ready`, `load_busy`, `load_done`, `load_err` = 0; `mem_waddr`, `mem_wdata`, `load_count` = 0; state RUN.
- Fetch path: zero latency, combinational from `fetch_addr`, `mem_rdata` and state.
- `load_start` at edge N -> `cpu_stall`/`byte_ready` high from cycle N+1.
- 4th byte accepted at edge M -> write in cycle M+1.
- Last word: DONE in cycle M+1, RUN and `cpu_stall`=0 in cycle M+2.
- Minimum session: 4·len accepted bytes + 2 cycles.
- `mem_we` is never high for two consecutive cycles (needs 4 bytes between writes).

## Configuration
- `IMEM_LOAD_TIMEOUT_EN` defined: idle counter runs in LOAD, cleared on each accepted byte. On reaching `TIMEOUT`:
  - `load_err` pulses one cycle.
  - Partial word discarded; -> RUN directly, no DONE, no `cpu_reset_req`.
  - `cpu_stall` drops the next cycle; `load_count` holds the words written.
- Undefined: no counter; LOAD waits indefinitely; `load_err` tied 0.

## Test plan
- Reset then RUN, `fetch_addr`=0x10, `mem_rdata`=0x00500093 -> `fetch_instr`=0x00500093, `mem_raddr`=4; `fetch_addr`=0x200 -> 0x00000063.
- `load_start`, `load_len`=2, bytes 93 00 50 00 13 01 A0 00 -> writes (0, 0x00500093), then (1, 0x00A00113); `load_done` and `cpu_reset_req` pulse once; `load_count`=2; `cpu_stall` low two cycles after last byte.
- `load_len`=300 -> clamps to 256; last write at `mem_waddr`=255; `byte_ready` low after 1024 bytes.
- `load_len`=0 with `load_start` -> stays RUN; `cpu_stall`=0; no writes.
- `rst` after 6 bytes of a 4-word load -> one write at address 0, none after; all outputs at reset values.
- With `IMEM_LOAD_TIMEOUT_EN`, `TIMEOUT`=16, 5 bytes then idle -> `load_err` pulse after 16 idle cycles, `load_count`=1, no `load_done`, `cpu_stall`=0 the next cycle.
